// File: rtl/bus_xfer_pkg.sv
// ----------------------------------------------------------------------------
// bus_xfer_pkg
// Shared types and constants for the bus-transfer initiator.
//   state_e : controller states (IDLE, DRIVE, LATCH, RELEASE)
//   IDX_W   : width of a bus-register index
//   DATA_W  : bus width
//   req_t   : a registered move request (src, dst, imm_en, imm)
// Optional feature macro used by the controller: BUS_XFER_TURNAROUND_EN
// ----------------------------------------------------------------------------
package bus_xfer_pkg;

  localparam int IDX_W  = 3;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_LATCH   = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0]  src;
    logic [IDX_W-1:0]  dst;
    logic              imm_en;
    logic [DATA_W-1:0] imm;
  } req_t;

endpackage

// File: rtl/bus_xfer_if.sv
// ----------------------------------------------------------------------------
// bus_xfer_if
// Request and strobe signals between the control unit (master) and the
// bus-transfer controller (slave).
//   req_valid/req_ready/req_src/req_dst/req_imm_en/req_imm : move request
//   out_en/in_en      : one-hot register output / load strobes
//   bus_oe/bus_out    : controller drives an immediate onto the bus
//   bus_in            : resolved bus value (monitor)
//   last_data         : bus value captured in the last LATCH cycle
//   done/err          : completion / rejection pulses
// ----------------------------------------------------------------------------
interface bus_xfer_if #(
  parameter int NUM_REGS = 6,
  parameter int DATA_W   = 8
);
  import bus_xfer_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [IDX_W-1:0]    req_src;
  logic [IDX_W-1:0]    req_dst;
  logic                req_imm_en;
  logic [DATA_W-1:0]   req_imm;
  logic [NUM_REGS-1:0] out_en;
  logic [NUM_REGS-1:0] in_en;
  logic                bus_oe;
  logic [DATA_W-1:0]   bus_out;
  logic [DATA_W-1:0]   bus_in;
  logic [DATA_W-1:0]   last_data;
  logic                done;
  logic                err;

  modport slave (
    input  req_valid, req_src, req_dst, req_imm_en, req_imm, bus_in,
    output req_ready, out_en, in_en, bus_oe, bus_out, last_data, done, err
  );

  modport master (
    output req_valid, req_src, req_dst, req_imm_en, req_imm, bus_in,
    input  req_ready, out_en, in_en, bus_oe, bus_out, last_data, done, err
  );

endinterface

// File: rtl/bus_onehot_dec.sv
// ----------------------------------------------------------------------------
// bus_onehot_dec
// Index to one-hot decoder with enable. Output is all zero when disabled or
// when the index is outside 0..N-1.
//   i_idx    : index to decode
//   i_en     : enable
//   o_onehot : one-hot result (combinational; registered by the parent)
// ----------------------------------------------------------------------------
module bus_onehot_dec #(
  parameter int N     = 6,
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_en,
  output logic [N-1:0]     o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int k = 0; k < N; k++) begin
      if (i_en && (i_idx == IDX_W'(k))) o_onehot[k] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// ----------------------------------------------------------------------------
// bus_xfer_ctrl
// Bus-transfer initiator for the shared CPU data bus. Accepts one
// register->register or immediate->register move at a time and sequences the
// per-register strobes so that at most one driver is ever active.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bus_xfer_if.slave (request side + strobe side)
// Macro BUS_XFER_TURNAROUND_EN: when defined, a RELEASE cycle with all strobes
// low follows LATCH (dead bus cycle between drivers, done pulses there).
// When undefined, done pulses in LATCH and LATCH returns straight to IDLE.
// ----------------------------------------------------------------------------
module bus_xfer_ctrl #(
  parameter int NUM_REGS = 6,
  parameter int DATA_W   = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  bus_xfer_if.slave bus
);
  import bus_xfer_pkg::*;

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_DRIVE   = ST_DRIVE;
  localparam logic [1:0] S_LATCH   = ST_LATCH;
  localparam logic [1:0] S_RELEASE = ST_RELEASE;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  req_t                r_req;
  logic                w_accept;
  logic                w_bad;
  logic [IDX_W-1:0]    w_src_idx;
  logic                w_imm_en;
  logic [DATA_W-1:0]   w_imm;
  logic                w_drive_nxt;
  logic                w_latch_nxt;
  logic                w_done_nxt;
  logic [NUM_REGS-1:0] w_out_en_d;
  logic [NUM_REGS-1:0] w_in_en_d;
  logic [NUM_REGS-1:0] r_out_en;
  logic [NUM_REGS-1:0] r_in_en;
  logic                r_bus_oe;
  logic [DATA_W-1:0]   r_bus_out;
  logic [DATA_W-1:0]   r_last_data;
  logic                r_done;
  logic                r_err;

  assign w_accept = bus.req_valid && (r_state == S_IDLE);

  always_comb begin
    w_bad = 1'b0;
    if (int'(bus.req_dst) >= NUM_REGS) w_bad = 1'b1;
    if (!bus.req_imm_en &&
        ((int'(bus.req_src) >= NUM_REGS) || (bus.req_src == bus.req_dst)))
      w_bad = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept && !w_bad) w_state_nxt = S_DRIVE;
      S_DRIVE:   w_state_nxt = S_LATCH;
`ifdef BUS_XFER_TURNAROUND_EN
      S_LATCH:   w_state_nxt = S_RELEASE;
`else
      S_LATCH:   w_state_nxt = S_IDLE;
`endif
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Strobes are decoded from the *next* state so that they can be registered
  // and appear glitch-free in the cycle they belong to. In IDLE the request
  // fields are taken straight from the port (acceptance edge).
  assign w_src_idx   = (r_state == S_IDLE) ? bus.req_src    : r_req.src;
  assign w_imm_en    = (r_state == S_IDLE) ? bus.req_imm_en : r_req.imm_en;
  assign w_imm       = (r_state == S_IDLE) ? bus.req_imm    : r_req.imm;
  assign w_drive_nxt = (w_state_nxt == S_DRIVE) || (w_state_nxt == S_LATCH);
  assign w_latch_nxt = (w_state_nxt == S_LATCH);
`ifdef BUS_XFER_TURNAROUND_EN
  assign w_done_nxt  = (w_state_nxt == S_RELEASE);
`else
  assign w_done_nxt  = w_latch_nxt;
`endif

  bus_onehot_dec #(.N(NUM_REGS), .IDX_W(IDX_W)) u_out_dec (
    .i_idx    (w_src_idx),
    .i_en     (w_drive_nxt && !w_imm_en),
    .o_onehot (w_out_en_d)
  );

  bus_onehot_dec #(.N(NUM_REGS), .IDX_W(IDX_W)) u_in_dec (
    .i_idx    (r_req.dst),
    .i_en     (w_latch_nxt),
    .o_onehot (w_in_en_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_en    <= '0;
      r_in_en     <= '0;
      r_bus_oe    <= 1'b0;
      r_bus_out   <= '0;
      r_last_data <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_out_en  <= w_out_en_d;
      r_in_en   <= w_in_en_d;
      r_bus_oe  <= w_drive_nxt && w_imm_en;
      r_bus_out <= (w_drive_nxt && w_imm_en) ? w_imm : '0;
      r_done    <= w_done_nxt;
      r_err     <= w_accept && w_bad;
      if (r_state == S_LATCH) r_last_data <= bus.bus_in;
    end
  end

  // Request fields are only meaningful after acceptance; no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_req.src    <= bus.req_src;
      r_req.dst    <= bus.req_dst;
      r_req.imm_en <= bus.req_imm_en;
      r_req.imm    <= bus.req_imm;
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.out_en    = r_out_en;
  assign bus.in_en     = r_in_en;
  assign bus.bus_oe    = r_bus_oe;
  assign bus.bus_out   = r_bus_out;
  assign bus.last_data = r_last_data;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
`timescale 1ns/1ps
module tb_bus_xfer_ctrl;
  localparam int NR = 6;
`ifdef BUS_XFER_TURNAROUND_EN
  localparam int L = 3;   // cycles from acceptance to done
`else
  localparam int L = 2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_xfer_if #(.NUM_REGS(NR), .DATA_W(8)) bif();
  bus_xfer_ctrl #(.NUM_REGS(NR), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Bus register bank model and bus resolution (wired-OR exposes collisions)
  logic [7:0] regs [NR];
  logic       pl_en;
  logic [2:0] pl_idx;
  logic [7:0] pl_val;

  always_comb begin
    bif.bus_in = 8'h00;
    for (int k = 0; k < NR; k++) if (bif.out_en[k]) bif.bus_in = bif.bus_in | regs[k];
    if (bif.bus_oe) bif.bus_in = bif.bus_in | bif.bus_out;
  end

  always @(posedge clk) begin
    if (pl_en) regs[pl_idx] <= pl_val;
    for (int k = 0; k < NR; k++) if (bif.in_en[k]) regs[k] <= bif.bus_in;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] idx, input logic [7:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic drive_req(input logic [2:0] s, input logic [2:0] d, input logic ie, input logic [7:0] im);
    bif.req_valid = 1'b1; bif.req_src = s; bif.req_dst = d;
    bif.req_imm_en = ie; bif.req_imm = im;
  endtask

  task automatic inv(input string tag);
    check({tag, "_drivers"}, 32'(($countones(bif.out_en) + int'(bif.bus_oe)) <= 1), 32'd1);
    check({tag, "_loads"}, 32'($countones(bif.in_en) <= 1), 32'd1);
    check({tag, "_busout_idle"}, 32'(!bif.bus_oe && (bif.bus_out != 8'h00)), 32'd0);
  endtask

  function automatic logic [5:0] oh(input logic [2:0] i);
    oh = (int'(i) < NR) ? (6'd1 << i) : 6'd0;
  endfunction

  typedef struct {
    logic [2:0] src;
    logic [2:0] dst;
    logic       imm_en;
    logic [7:0] imm;
    logic [7:0] preload;
    logic       exp_err;
    logic [5:0] exp_out;
    logic [5:0] exp_in;
    logic [7:0] exp_val;
  } vec_t;

  typedef struct {
    logic       ready;
    logic [5:0] out;
    logic [5:0] inn;
    logic       oe;
    logic [7:0] bo;
    logic       done;
    logic       err;
    logic       chk;
    logic [2:0] dst;
    logic [7:0] val;
  } slot_t;

  function automatic slot_t idle_slot();
    slot_t s;
    s.ready = 1'b1; s.out = '0; s.inn = '0; s.oe = 1'b0; s.bo = '0;
    s.done = 1'b0; s.err = 1'b0; s.chk = 1'b0; s.dst = '0; s.val = '0;
    return s;
  endfunction

  task automatic run_vec(input vec_t v, input int n);
    string p;
    p = $sformatf("v%0d", n);
    if (!v.imm_en && int'(v.src) < NR) preload(v.src, v.preload);
    check({p, "_ready0"}, 32'(bif.req_ready), 32'd1);
    drive_req(v.src, v.dst, v.imm_en, v.imm);
    tick();
    bif.req_valid = 1'b0;
    if (v.exp_err) begin
      check({p, "_err"}, 32'(bif.err), 32'd1);
      check({p, "_err_out"}, 32'(bif.out_en), 32'd0);
      check({p, "_err_in"}, 32'(bif.in_en), 32'd0);
      check({p, "_err_oe"}, 32'(bif.bus_oe), 32'd0);
      check({p, "_err_ready"}, 32'(bif.req_ready), 32'd1);
      tick();
      check({p, "_err_clr"}, 32'(bif.err), 32'd0);
      check({p, "_err_in2"}, 32'(bif.in_en), 32'd0);
    end else begin
      for (int c = 1; c <= L + 1; c++) begin
        check({p, "_out"}, 32'(bif.out_en), 32'((c <= 2) ? v.exp_out : 6'd0));
        check({p, "_in"}, 32'(bif.in_en), 32'((c == 2) ? v.exp_in : 6'd0));
        check({p, "_oe"}, 32'(bif.bus_oe), 32'(c <= 2 && v.imm_en));
        check({p, "_busout"}, 32'(bif.bus_out), 32'((c <= 2 && v.imm_en) ? v.imm : 8'h00));
        check({p, "_done"}, 32'(bif.done), 32'(c == L));
        check({p, "_ready"}, 32'(bif.req_ready), 32'(c == L + 1));
        check({p, "_noerr"}, 32'(bif.err), 32'd0);
        inv(p);
        if (c == L + 1) begin
          check({p, "_last_data"}, 32'(bif.last_data), 32'(v.exp_val));
          check({p, "_reg_dst"}, 32'(regs[v.dst]), 32'(v.exp_val));
        end else begin
          tick();
        end
      end
    end
  endtask

  vec_t  vecs [8];
  slot_t sb [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int     n_acc, n_de, last_acc;
    slot_t  s;
    logic [2:0] rs, rd;
    logic       ri;
    logic [7:0] rim;
    logic       bad;

    vecs[0] = '{3'd1, 3'd3, 1'b0, 8'h00, 8'hA5, 1'b0, 6'b000010, 6'b001000, 8'hA5};
    vecs[1] = '{3'd0, 3'd0, 1'b1, 8'h3C, 8'h00, 1'b0, 6'b000000, 6'b000001, 8'h3C};
    vecs[2] = '{3'd2, 3'd2, 1'b0, 8'h00, 8'h22, 1'b1, 6'b000000, 6'b000000, 8'h00};
    vecs[3] = '{3'd0, 3'd7, 1'b0, 8'h00, 8'h33, 1'b1, 6'b000000, 6'b000000, 8'h00};
    vecs[4] = '{3'd0, 3'd6, 1'b1, 8'h99, 8'h00, 1'b1, 6'b000000, 6'b000000, 8'h00};
    vecs[5] = '{3'd5, 3'd4, 1'b0, 8'h00, 8'h5A, 1'b0, 6'b100000, 6'b010000, 8'h5A};
    vecs[6] = '{3'd6, 3'd1, 1'b0, 8'h00, 8'h00, 1'b1, 6'b000000, 6'b000000, 8'h00};
    vecs[7] = '{3'd3, 3'd5, 1'b1, 8'hFF, 8'h00, 1'b0, 6'b000000, 6'b100000, 8'hFF};

    rst_n = 1'b0;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    bif.req_valid = 1'b0; bif.req_src = '0; bif.req_dst = '0;
    bif.req_imm_en = 1'b0; bif.req_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bif.req_ready), 32'd1);
    check("rst_out", 32'(bif.out_en), 32'd0);
    check("rst_in", 32'(bif.in_en), 32'd0);
    check("rst_oe", 32'(bif.bus_oe), 32'd0);
    check("rst_busout", 32'(bif.bus_out), 32'd0);
    check("rst_last", 32'(bif.last_data), 32'd0);
    check("rst_done", 32'(bif.done), 32'd0);
    check("rst_err", 32'(bif.err), 32'd0);
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < NR; k++) preload(3'(k), 8'(16 * k + 1));

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Back-to-back: valid held high, fields swapped after the first acceptance
    preload(3'd4, 8'h4D);
    check("b2b_ready0", 32'(bif.req_ready), 32'd1);
    drive_req(3'd4, 3'd5, 1'b0, 8'h00);
    tick();
    drive_req(3'd0, 3'd1, 1'b1, 8'h77);
    for (int c = 1; c <= 2 * L + 2; c++) begin
      if (c == L + 2) bif.req_valid = 1'b0;
      check("b2b_out", 32'(bif.out_en), 32'((c <= 2) ? 6'b010000 : 6'd0));
      check("b2b_in", 32'(bif.in_en),
            32'((c == 2) ? 6'b100000 : (c == L + 3) ? 6'b000010 : 6'd0));
      check("b2b_oe", 32'(bif.bus_oe), 32'(c == L + 2 || c == L + 3));
      check("b2b_busout", 32'(bif.bus_out), 32'((c == L + 2 || c == L + 3) ? 8'h77 : 8'h00));
      check("b2b_done", 32'(bif.done), 32'(c == L || c == 2 * L + 1));
      check("b2b_ready", 32'(bif.req_ready), 32'(c == L + 1 || c == 2 * L + 2));
      inv("b2b");
      if (c < 2 * L + 2) tick();
    end
    check("b2b_reg5", 32'(regs[5]), 32'h4D);
    check("b2b_reg1", 32'(regs[1]), 32'h77);
    check("b2b_last", 32'(bif.last_data), 32'h77);

    // Reset asserted during LATCH
    preload(3'd0, 8'h11);
    drive_req(3'd0, 3'd2, 1'b0, 8'h00);
    tick();
    bif.req_valid = 1'b0;
    tick();
    check("rstl_in_latch", 32'(bif.in_en), 32'b000100);
    #2 rst_n = 1'b0;
    #1;
    check("rstl_out", 32'(bif.out_en), 32'd0);
    check("rstl_in", 32'(bif.in_en), 32'd0);
    check("rstl_oe", 32'(bif.bus_oe), 32'd0);
    check("rstl_ready", 32'(bif.req_ready), 32'd1);
    tick();
    check("rstl_nodone", 32'(bif.done), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rstl_ready2", 32'(bif.req_ready), 32'd1);
    check("rstl_nodone2", 32'(bif.done), 32'd0);
    check("rstl_in2", 32'(bif.in_en), 32'd0);
    for (int k = 0; k < NR; k++) preload(3'(k), 8'(8'hC0 + k));

    // Random soak against a timeline scoreboard
    for (int i = 0; i < 8; i++) sb[i] = idle_slot();
    n_acc = 0; n_de = 0; last_acc = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      s = sb[cyc % 8];
      check("soak_ready", 32'(bif.req_ready), 32'(s.ready));
      check("soak_out", 32'(bif.out_en), 32'(s.out));
      check("soak_in", 32'(bif.in_en), 32'(s.inn));
      check("soak_oe", 32'(bif.bus_oe), 32'(s.oe));
      check("soak_busout", 32'(bif.bus_out), 32'(s.bo));
      check("soak_done", 32'(bif.done), 32'(s.done));
      check("soak_err", 32'(bif.err), 32'(s.err));
      inv("soak");
      if (s.chk) begin
        check("soak_last", 32'(bif.last_data), 32'(s.val));
        check("soak_reg", 32'(regs[s.dst]), 32'(s.val));
      end
      if (bif.done) n_de++;
      if (bif.err)  n_de++;
      sb[cyc % 8] = idle_slot();

      if (n_acc < 1000) begin
        rs = 3'($urandom_range(0, 7));
        rd = 3'($urandom_range(0, 7));
        ri = ($urandom_range(0, 3) == 0);
        rim = 8'($urandom);
        drive_req(rs, rd, ri, rim);
        bif.req_valid = ($urandom_range(0, 3) != 0);
      end else begin
        bif.req_valid = 1'b0;
        if (cyc > last_acc + 8) break;
      end

      if (bif.req_valid && s.ready) begin
        n_acc++;
        last_acc = cyc;
        bad = (int'(rd) >= NR) || (!ri && (int'(rs) >= NR || rs == rd));
        if (bad) begin
          sb[(cyc + 1) % 8].err = 1'b1;
        end else begin
          for (int k = 1; k <= 2; k++) begin
            sb[(cyc + k) % 8].out = ri ? 6'd0 : oh(rs);
            sb[(cyc + k) % 8].oe  = ri;
            sb[(cyc + k) % 8].bo  = ri ? rim : 8'h00;
          end
          sb[(cyc + 2) % 8].inn = oh(rd);
          for (int k = 1; k <= L; k++) sb[(cyc + k) % 8].ready = 1'b0;
          sb[(cyc + L) % 8].done = 1'b1;
          sb[(cyc + 3) % 8].chk  = 1'b1;
          sb[(cyc + 3) % 8].dst  = rd;
          sb[(cyc + 3) % 8].val  = ri ? rim : regs[rs];
        end
      end
      tick();
    end
    check("soak_accepted", 32'(n_acc), 32'd1000);
    check("soak_done_or_err", 32'(n_de), 32'(n_acc));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
